// File: rtl/ps2_axi_rx.sv
// rtl/ps2_axi_rx.sv - PS/2 device receiver with FIFO and AXI4-Lite register access (optional irq via PS2_IRQ_EN)
module ps2_axi_rx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY
`ifdef PS2_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    // synchroniser / filter state
    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          bit_strobe;

    // receive FSM state
    rx_state_t     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic          ev_ok, ev_perr, ev_ferr;

    // frame outcome, applied the cycle after the stop bit sample
    logic          push_pend;
    logic [7:0]    push_byte;
    logic          perr_set, ferr_set;

    // FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full;
    logic          do_push, do_pop, ovf_set;

    // registers
    logic          en_q, irqen;
    logic          ovf_q, perr_q, ferr_q;
    logic [2:0]    st_clr;

    // AXI channel state
    logic          arready_q, rvalid_q;
    logic [31:0]   rdata_q;
    logic [1:0]    rresp_q;
    logic          awready_q, bvalid_q;
    logic [1:0]    bresp_q;
    logic          ar_hs, wr_hs;
    logic [31:0]   rd_mux;
    logic [1:0]    rd_resp;
    logic          unused_bits;

    assign unused_bits = ^{ARADDR[31:4], ARADDR[1:0], AWADDR[31:4], AWADDR[1:0],
                           WDATA[31:4], WSTRB[3:1]};

    // two-flop synchronisers for both PS/2 lines
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // accept a ps2_clk level only after FILTER_LEN equal samples; strobe one cycle after a falling edge
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            filt_clk   <= 1'b1;
            filt_cnt   <= '0;
            bit_strobe <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk   <= clk_s2;
                filt_cnt   <= '0;
                bit_strobe <= ~clk_s2;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // receive FSM state register
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            to_q      <= to_d;
        end
    end

    // receive FSM next state: start, 8 data bits LSB first, parity, stop; timeout abandons the frame
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_d      = '0;
        ev_ok     = 1'b0;
        ev_perr   = 1'b0;
        ev_ferr   = 1'b0;
        if (!en_q) begin
            state_d = S_IDLE;
        end else begin
            if (state_q != S_IDLE && !bit_strobe) begin
                to_d = to_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (bit_strobe && !data_s2) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                        par_d     = 1'b0;
                    end
                end
                S_DATA: begin
                    if (bit_strobe) begin
                        shift_d = {data_s2, shift_q[7:1]};
                        par_d   = par_q ^ data_s2;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_PARITY;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_strobe) begin
                        par_d   = par_q ^ data_s2;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_strobe) begin
                        state_d = S_IDLE;
                        if (!data_s2) begin
                            ev_ferr = 1'b1;
                        end else if (!par_q) begin
                            ev_perr = 1'b1;
                        end else begin
                            ev_ok = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (state_q != S_IDLE && !bit_strobe && to_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = S_IDLE;
                to_d    = '0;
            end
        end
    end

    // register the frame outcome so the push lands the cycle after the stop bit sample
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            push_pend <= 1'b0;
            push_byte <= '0;
            perr_set  <= 1'b0;
            ferr_set  <= 1'b0;
        end else begin
            push_pend <= ev_ok;
            perr_set  <= ev_perr;
            ferr_set  <= ev_ferr;
            if (ev_ok) begin
                push_byte <= shift_q;
            end
        end
    end

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign ar_hs      = arready_q & ARVALID;
    assign wr_hs      = awready_q & AWVALID & WVALID;
    assign do_pop     = ar_hs && (ARADDR[3:2] == 2'd0) && !fifo_empty;
    assign do_push    = push_pend && (!fifo_full || do_pop);
    assign ovf_set    = push_pend && fifo_full && !do_pop;

    // FIFO storage
    always_ff @(posedge ACLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_byte;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign st_clr = (wr_hs && AWADDR[3:2] == 2'd1 && WSTRB[0]) ? WDATA[3:1] : 3'b000;

    // sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ovf_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_set  | (ovf_q  & ~st_clr[0]);
            perr_q <= perr_set | (perr_q & ~st_clr[1]);
            ferr_q <= ferr_set | (ferr_q & ~st_clr[2]);
        end
    end

    // CTRL.EN register
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            en_q <= 1'b0;
        end else if (wr_hs && AWADDR[3:2] == 2'd2 && WSTRB[0]) begin
            en_q <= WDATA[0];
        end
    end

`ifdef PS2_IRQ_EN
    logic irqen_q;
    logic irq_q;

    // CTRL.IRQEN register
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            irqen_q <= 1'b0;
        end else if (wr_hs && AWADDR[3:2] == 2'd2 && WSTRB[0]) begin
            irqen_q <= WDATA[1];
        end
    end

    assign irqen = irqen_q;

    // registered level interrupt
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irqen_q & (~fifo_empty | ovf_q | perr_q | ferr_q);
        end
    end

    assign irq = irq_q;
`else
    assign irqen = 1'b0;
`endif

    // read data mux by register index
    always_comb begin
        rd_mux  = '0;
        rd_resp = 2'b00;
        case (ARADDR[3:2])
            2'd0: begin
                if (!fifo_empty) begin
                    rd_mux = {23'b0, 1'b1, mem[rd_ptr]};
                end
            end
            2'd1: rd_mux = {{(16 - CW){1'b0}}, fifo_count, 12'b0, ferr_q, perr_q, ovf_q, fifo_empty};
            2'd2: rd_mux = {30'b0, irqen, en_q};
            default: rd_resp = 2'b10;
        endcase
    end

    // read channel: one-cycle ARREADY pulse, response held until RREADY
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            arready_q <= ARVALID && !arready_q && !rvalid_q;
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
                rresp_q  <= rd_resp;
            end else if (rvalid_q && RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // write channel: AWREADY/WREADY together when both valids present, response held until BREADY
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            awready_q <= AWVALID && WVALID && !awready_q && !bvalid_q;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (AWADDR[3:2] == 2'd3) ? 2'b10 : 2'b00;
            end else if (bvalid_q && BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign AWREADY = awready_q;
    assign WREADY  = awready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;

endmodule
